rvvicmddecode: RTL and testbench

Parametrised host-command decoder for the hardware tracer's Ethernet receive path. It compares every received frame against `NUM_CMDS` programmable header strings at once, and captures a multi-word payload for each command that matches. Each match produces a one-cycle strobe. It replaces the single-string trigger detectors: one instance serves the trigger, slow-down, rate-set and future commands. It sits between the MAC receive AXI-stream output and the tracer control logic (stall generator, packetizer delay, ILA trigger).

---
 rtl/rvvicmddecode.sv | 161 ++++++++++++++++
 tb/tb_rvvicmddecode.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rvvicmddecode.sv
`default_nettype none
// ============================================================================
// Module   : rvvicmddecode
// Brief    : Multi-channel host-command decoder on the RVVI Ethernet RX stream.
//            Matches frame headers against NUM_CMDS strings, captures payload.
// Revision : 1.0 - initial release
// ============================================================================
module rvvicmddecode #(
  parameter int                     NUM_CMDS  = 3,
  parameter int                     HDR_WORDS = 5,
  parameter int                     MSG_WORDS = 1,
  parameter logic [MSG_WORDS*32-1:0] MSG_RESET = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       RvviAxiRdata,
  input  logic [3:0]                        RvviAxiRstrb,
  input  logic                              RvviAxiRlast,
  input  logic                              RvviAxiRvalid,
  input  logic [NUM_CMDS*HDR_WORDS*32-1:0]  CompareStrings,
  output logic [NUM_CMDS-1:0]               CmdValid,
  output logic [NUM_CMDS*MSG_WORDS*32-1:0]  CmdMessage,
  output logic [15:0]                       DropCount
);

  localparam logic [1:0] c_ST_HDR  = 2'd0;
  localparam logic [1:0] c_ST_MSG  = 2'd1;
  localparam logic [1:0] c_ST_SKIP = 2'd2;

  localparam logic [4:0] c_HDR_LAST = 5'(HDR_WORDS - 1);
  localparam logic [4:0] c_MSG_LAST = 5'(HDR_WORDS + MSG_WORDS - 1);
  localparam logic [4:0] c_TOTAL    = 5'(HDR_WORDS + MSG_WORDS);

  logic [1:0]                      r_state;
  logic [1:0]                      w_state_next;
  logic [4:0]                      r_idx;
  logic [4:0]                      w_idx_next;
  logic [NUM_CMDS-1:0]             r_match;
  logic [NUM_CMDS-1:0]             w_match_next;
  logic [NUM_CMDS-1:0]             w_beat_hit;
  logic [NUM_CMDS-1:0]             w_match_now;
  logic [NUM_CMDS-1:0]             w_fire;
  logic [MSG_WORDS*32-1:0]         r_stage;
  logic [MSG_WORDS*32-1:0]         w_stage_next;
  logic [31:0]                     w_beat_data;
  logic                            w_strb_full;
  logic                            w_complete;
  logic                            w_frame_ok;
  logic [NUM_CMDS-1:0]             r_cmd_valid;
  logic [NUM_CMDS*MSG_WORDS*32-1:0] r_cmd_message;
  logic [15:0]                     r_drop_count;

  assign w_strb_full = (RvviAxiRstrb == 4'hF);

  // Payload bytes without a strobe are stored as zero.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign w_beat_data[b*8 +: 8] = RvviAxiRstrb[b] ? RvviAxiRdata[b*8 +: 8] : 8'h00;
  end

  for (genvar c = 0; c < NUM_CMDS; c++) begin : g_chan
    logic [31:0] w_ref_word;
    always_comb begin
      w_ref_word = '0;
      for (int i = 0; i < HDR_WORDS; i++) begin
        if (r_idx == 5'(i)) begin
          w_ref_word = CompareStrings[c*HDR_WORDS*32 + i*32 +: 32];
        end
      end
    end
    assign w_beat_hit[c] = w_strb_full && (RvviAxiRdata == w_ref_word);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_HDR;
      r_idx   <= '0;
      r_match <= '1;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_match <= w_match_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_match_next = r_match;
    if (RvviAxiRvalid) begin
      if (RvviAxiRlast) begin
        w_state_next = c_ST_HDR;
        w_idx_next   = '0;
        w_match_next = '1;
      end else begin
        if (r_idx != c_TOTAL) begin
          w_idx_next = r_idx + 5'd1;
        end
        case (r_state)
          c_ST_HDR: begin
            w_match_next = w_match_now;
            if (r_idx == c_HDR_LAST) begin
              w_state_next = (|w_match_now) ? c_ST_MSG : c_ST_SKIP;
            end
          end
          c_ST_MSG: begin
            if (r_idx == c_MSG_LAST) begin
              w_state_next = c_ST_SKIP;
            end
          end
          default: begin
            w_state_next = r_state;
          end
        endcase
      end
    end
  end

  // Output logic: the completing beat's own compare and payload are folded in.
  always_comb begin
    w_match_now  = (r_state == c_ST_HDR) ? (r_match & w_beat_hit) : r_match;
    w_stage_next = r_stage;
    if (RvviAxiRvalid && (r_state == c_ST_MSG)) begin
      for (int j = 0; j < MSG_WORDS; j++) begin
        if (r_idx == 5'(HDR_WORDS + j)) begin
          w_stage_next[j*32 +: 32] = w_beat_data;
        end
      end
    end
    w_complete = RvviAxiRvalid && RvviAxiRlast;
    w_frame_ok = (r_idx >= c_MSG_LAST) && (|w_match_now);
    w_fire     = (w_complete && w_frame_ok) ? w_match_now : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage       <= '0;
      r_cmd_valid   <= '0;
      r_cmd_message <= {NUM_CMDS{MSG_RESET}};
      r_drop_count  <= '0;
    end else begin
      r_stage     <= w_stage_next;
      r_cmd_valid <= w_fire;
      for (int c = 0; c < NUM_CMDS; c++) begin
        if (w_fire[c]) begin
          r_cmd_message[c*MSG_WORDS*32 +: MSG_WORDS*32] <= w_stage_next;
        end
      end
      if (w_complete && !w_frame_ok && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign CmdValid   = r_cmd_valid;
  assign CmdMessage = r_cmd_message;
  assign DropCount  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_rvvicmddecode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvvicmddecode
// Brief    : Scoreboard bench for rvvicmddecode (1-word and 2-word payload).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvvicmddecode;

  localparam logic [159:0] c_STR_T = 160'h6e696769_7274005c_8f540000_16544502_11116843;
  localparam logic [159:0] c_STR_S = 160'h00000004_00000003_00000002_00000001_deadbeef;
  localparam logic [31:0]  c_RST1  = 32'hA5A50001;
  localparam logic [63:0]  c_RST2  = 64'hCAFE0002_CAFE0001;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        last, valid1, valid2;
  logic [2:0]  cmd_valid1;
  logic [95:0] cmd_msg1;
  logic [15:0] drop1;
  logic [0:0]  cmd_valid2;
  logic [63:0] cmd_msg2;
  logic [15:0] drop2;

  always #5 clk = ~clk;

  rvvicmddecode #(.NUM_CMDS(3), .HDR_WORDS(5), .MSG_WORDS(1), .MSG_RESET(c_RST1)) dut1 (
    .clk(clk), .reset(rst1), .RvviAxiRdata(data), .RvviAxiRstrb(strb),
    .RvviAxiRlast(last), .RvviAxiRvalid(valid1),
    .CompareStrings({c_STR_S, c_STR_S, c_STR_T}),
    .CmdValid(cmd_valid1), .CmdMessage(cmd_msg1), .DropCount(drop1));

  rvvicmddecode #(.NUM_CMDS(1), .HDR_WORDS(5), .MSG_WORDS(2), .MSG_RESET(c_RST2)) dut2 (
    .clk(clk), .reset(rst2), .RvviAxiRdata(data), .RvviAxiRstrb(strb),
    .RvviAxiRlast(last), .RvviAxiRvalid(valid2),
    .CompareStrings(c_STR_T),
    .CmdValid(cmd_valid2), .CmdMessage(cmd_msg2), .DropCount(drop2));

  typedef struct packed {
    logic [2:0]  v;
    logic [95:0] m;
    logic [15:0] d;
  } exp1_t;

  exp1_t       q1[$];
  logic [63:0] q2[$];
  exp1_t       e1;
  logic [63:0] e2;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [95:0] mdl_msg;
  logic [15:0] mdl_drop;
  logic [15:0] prev_drop;
  bit          mon_en = 1'b0;
  bit          gaps = 1'b0;
  logic [31:0] fw[16];
  logic [3:0]  fs[16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A result is presented whenever a pulse fires or the drop counter moves.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid1 != 3'b0 || drop1 != prev_drop) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out1: got valid=%0h drop=%0h expected nothing", cmd_valid1, drop1);
        end else begin
          e1 = q1.pop_front();
          check("cmd_valid1", 128'(cmd_valid1), 128'(e1.v));
          check("cmd_msg1", 128'(cmd_msg1), 128'(e1.m));
          check("drop1", 128'(drop1), 128'(e1.d));
        end
      end
      prev_drop = drop1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && cmd_valid2 != 1'b0) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out2: got msg=%0h expected no pulse", cmd_msg2);
      end else begin
        e2 = q2.pop_front();
        check("cmd_msg2", 128'(cmd_msg2), 128'(e2));
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l, input bit sel2);
    @(posedge clk); #1;
    if (gaps) begin
      int k;
      k = $urandom_range(0, 2);
      repeat (k) begin
        valid1 = 1'b0; valid2 = 1'b0;
        @(posedge clk); #1;
      end
    end
    data = d; strb = s; last = l;
    valid1 = !sel2; valid2 = sel2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid1 = 1'b0; valid2 = 1'b0; last = 1'b0;
    end
  endtask

  task automatic set_hdr(input logic [159:0] s);
    for (int i = 0; i < 16; i++) fs[i] = 4'hF;
    for (int i = 0; i < 5; i++) fw[i] = s[i*32 +: 32];
  endtask

  // Expected mask and payload are supplied by hand for each frame.
  task automatic send1(input int n, input logic [2:0] mask, input logic [31:0] pay);
    for (int c = 0; c < 3; c++) if (mask[c]) mdl_msg[c*32 +: 32] = pay;
    if (mask != 3'b0) begin
      q1.push_back({mask, mdl_msg, mdl_drop});
    end else if (mdl_drop != 16'hFFFF) begin
      mdl_drop = mdl_drop + 16'd1;
      q1.push_back({3'b0, mdl_msg, mdl_drop});
    end
    for (int i = 0; i < n; i++) beat(fw[i], fs[i], (i == n - 1), 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    last = 1'b0; data = '0; strb = 4'hF;
    mdl_msg = {3{c_RST1}}; mdl_drop = '0;
    repeat (3) @(posedge clk);
    #1; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset_valid1", 128'(cmd_valid1), 128'(0));
    check("reset_msg1", 128'(cmd_msg1), 128'({3{c_RST1}}));
    check("reset_drop1", 128'(drop1), 128'(0));
    check("reset_msg2", 128'(cmd_msg2), 128'(c_RST2));
    prev_drop = drop1;
    mon_en = 1'b1;

    set_hdr(c_STR_T); fw[5] = 32'h40;                          send1(6, 3'b001, 32'h40);
    set_hdr(c_STR_T); fw[4] = 32'h6e696768; fw[5] = 32'h40;    send1(6, 3'b000, 32'h0);
    set_hdr(c_STR_T);                                          send1(5, 3'b000, 32'h0);
    set_hdr(c_STR_S); fw[5] = 32'h5;                           send1(6, 3'b110, 32'h5);
    set_hdr(c_STR_S); fw[5] = 32'h9;                           send1(6, 3'b110, 32'h9);
    set_hdr(c_STR_T); fs[2] = 4'h7; fw[5] = 32'h40;            send1(6, 3'b000, 32'h0);
    set_hdr(c_STR_T); fw[5] = 32'hAABBCCDD; fs[5] = 4'h3;      send1(6, 3'b001, 32'h0000CCDD);
    gaps = 1'b1;
    set_hdr(c_STR_T); fw[5] = 32'h77;                          send1(6, 3'b001, 32'h77);
    set_hdr(c_STR_S); fw[5] = 32'h123; fw[6] = 32'hFFFFFFFF;   send1(7, 3'b110, 32'h123);
    gaps = 1'b0;
    idle(4);

    set_hdr(c_STR_T); fw[5] = 32'h11111111; fw[6] = 32'h22222222; fw[7] = 32'h33333333;
    q2.push_back(64'h22222222_11111111);
    for (int i = 0; i < 8; i++) beat(fw[i], fs[i], (i == 7), 1'b1);
    idle(3);
    check("msg2_held", 128'(cmd_msg2), 128'(64'h22222222_11111111));
    check("drop2_zero", 128'(drop2), 128'(0));
    for (int i = 0; i < 3; i++) beat(fw[i], fs[i], 1'b0, 1'b1);
    @(posedge clk); #1; valid2 = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1; rst2 = 1'b0;
    check("msg2_after_reset", 128'(cmd_msg2), 128'(c_RST2));
    check("drop2_after_reset", 128'(drop2), 128'(0));
    for (int i = 3; i < 8; i++) beat(fw[i], fs[i], (i == 7), 1'b1);
    idle(3);
    check("drop2_tail", 128'(drop2), 128'(1));
    check("msg2_tail", 128'(cmd_msg2), 128'(c_RST2));

    fw[0] = 32'h0;
    for (int k = 0; k < 65540; k++) send1(1, 3'b000, 32'h0);
    idle(3);
    check("drop1_saturated", 128'(drop1), 128'(16'hFFFF));
    set_hdr(c_STR_T); fw[5] = 32'h1;                           send1(6, 3'b001, 32'h1);
    idle(5);
    check("drop1_holds", 128'(drop1), 128'(16'hFFFF));
    check("q1_drained", 128'(q1.size()), 128'(0));
    check("q2_drained", 128'(q2.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
